wb_serial_divmod: RTL and testbench

// Wishbone-mapped multicycle integer divider; successor to the fixed serial divider.

---
 rtl/wb_serial_divmod.sv | 211 +++++++++++++++++++++
 tb/tb_wb_serial_divmod.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_divmod.sv
// Wishbone-mapped multicycle restoring divider with signed/unsigned mode,
// RISC-V style divide-by-zero/overflow results, done interrupt and byte-lane writes.
module wb_serial_divmod #(
    parameter int              WBW       = 32,
    parameter int              LAW       = 32,
    parameter int              XLEN      = 32,
    parameter logic [WBW-1:0]  BASE_ADDR = 32'h3000_0000,
    parameter int              BLINK_W   = 24
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [WBW/8-1:0]   wbs_sel_i,
    input  logic [WBW-1:0]     wbs_adr_i,
    input  logic [WBW-1:0]     wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [WBW-1:0]     wbs_dat_o,
    output logic [LAW-1:0]     la_data_o,
    output logic               irq_o,
    output logic               hw_blinky_o,
    output logic               sw_blinky_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3
    } state_t;

    state_t state_q, state_d;

    logic              ack_q;
    logic [WBW-1:0]    dat_q;
    logic [XLEN-1:0]   dividend_q, divisor_q, quot_q, rem_q;
    logic              ctl_signed_q, ctl_ie_q, ctl_blink_q;
    logic              busy_q, done_q, div0_q, ovf_q;
    logic [XLEN-1:0]   acc_q, rsd_q, dsr_q;
    logic              neg_q_q, neg_r_q, skip_q;
    logic [CW-1:0]     cnt_q;
    logic [BLINK_W-1:0] blink_q;

    logic              hit, req, wr, rd, start_go, w1c_done;
    logic [7:0]        off;
    logic [WBW-1:0]    rd_data;
    logic              dd_neg, dv_neg, div0_c, ovf_c;
    logic [XLEN-1:0]   dd_abs, dv_abs;
    logic [XLEN:0]     rs, diff;
    logic              step_ok;
    logic [XLEN-1:0]   rsd_next, acc_next, q_fix, r_fix;

    always_comb begin
        hit      = wbs_adr_i[WBW-1:8] == BASE_ADDR[WBW-1:8];
        off      = wbs_adr_i[7:0];
        req      = wbs_stb_i & wbs_cyc_i & ~ack_q;
        wr       = req & wbs_we_i & hit;
        rd       = req & ~wbs_we_i;
        start_go = wr && off == 8'h08 && wbs_sel_i[0] && wbs_dat_i[0] && !busy_q;
        w1c_done = wr && off == 8'h0C && wbs_sel_i[0] && wbs_dat_i[1];

        rd_data = '0;
        if (hit) begin
            case (off)
                8'h00: rd_data[XLEN-1:0] = dividend_q;
                8'h04: rd_data[XLEN-1:0] = divisor_q;
                8'h08: rd_data[3:0]      = {ctl_blink_q, ctl_ie_q, ctl_signed_q, 1'b0};
                8'h0C: rd_data[3:0]      = {ovf_q, div0_q, done_q, busy_q};
                8'h10: rd_data[XLEN-1:0] = quot_q;
                8'h14: rd_data[XLEN-1:0] = rem_q;
                default: rd_data = '0;
            endcase
        end

        dd_neg = ctl_signed_q & dividend_q[XLEN-1];
        dv_neg = ctl_signed_q & divisor_q[XLEN-1];
        dd_abs = dd_neg ? -dividend_q : dividend_q;
        dv_abs = dv_neg ? -divisor_q : divisor_q;
        div0_c = divisor_q == '0;
        ovf_c  = ctl_signed_q && dividend_q == MIN_V && (&divisor_q);

        // Restoring step: shift next dividend bit into the partial remainder.
        rs       = {rsd_q, acc_q[XLEN-1]};
        diff     = rs - {1'b0, dsr_q};
        step_ok  = ~diff[XLEN];
        rsd_next = step_ok ? diff[XLEN-1:0] : rs[XLEN-1:0];
        acc_next = {acc_q[XLEN-2:0], step_ok};

        q_fix = (neg_q_q && !skip_q) ? -acc_q : acc_q;
        r_fix = (neg_r_q && !skip_q) ? -rsd_q : rsd_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_go) state_d = S_LOAD;
            S_LOAD: state_d = (div0_c || ovf_c) ? S_FIX : S_ITER;
            S_ITER: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            ctl_signed_q <= 1'b0;
            ctl_ie_q     <= 1'b0;
            ctl_blink_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            div0_q       <= 1'b0;
            ovf_q        <= 1'b0;
            acc_q        <= '0;
            rsd_q        <= '0;
            dsr_q        <= '0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            skip_q       <= 1'b0;
            cnt_q        <= '0;
            blink_q      <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= req;
            dat_q   <= rd ? rd_data : '0;
            blink_q <= blink_q + 1'b1;

            if (wr) begin
                for (int b = 0; b < XLEN/8; b++) begin
                    if (wbs_sel_i[b] && off == 8'h00) dividend_q[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                    if (wbs_sel_i[b] && off == 8'h04) divisor_q[b*8 +: 8]  <= wbs_dat_i[b*8 +: 8];
                end
                if (off == 8'h08 && wbs_sel_i[0]) begin
                    ctl_signed_q <= wbs_dat_i[1];
                    ctl_ie_q     <= wbs_dat_i[2];
                    ctl_blink_q  <= wbs_dat_i[3];
                end
            end

            if (start_go) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                div0_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (w1c_done) done_q <= 1'b0;

            case (state_q)
                S_LOAD: begin
                    neg_q_q <= dd_neg ^ dv_neg;
                    neg_r_q <= dd_neg;
                    cnt_q   <= CW'(XLEN-1);
                    skip_q  <= 1'b0;
                    dsr_q   <= dv_abs;
                    acc_q   <= dd_abs;
                    rsd_q   <= '0;
                    if (div0_c) begin
                        acc_q  <= '1;
                        rsd_q  <= dividend_q;
                        div0_q <= 1'b1;
                        skip_q <= 1'b1;
                    end else if (ovf_c) begin
                        acc_q  <= MIN_V;
                        rsd_q  <= '0;
                        ovf_q  <= 1'b1;
                        skip_q <= 1'b1;
                    end
                end
                S_ITER: begin
                    acc_q <= acc_next;
                    rsd_q <= rsd_next;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    // Placed after the W1C clear so a same-cycle completion keeps done set.
                    quot_q <= q_fix;
                    rem_q  <= r_fix;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        la_data_o          = '0;
        la_data_o[2:0]     = state_q;
        la_data_o[3]       = busy_q;
        la_data_o[4]       = done_q;
        la_data_o[5]       = div0_q;
        la_data_o[6]       = ovf_q;
        la_data_o[8 +: CW] = cnt_q;
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign irq_o       = done_q & ctl_ie_q;
    assign hw_blinky_o = blink_q[BLINK_W-1];
    assign sw_blinky_o = ctl_blink_q;

endmodule

// File: tb/tb_wb_serial_divmod.sv
// Directed bench for wb_serial_divmod: vector table of divisions plus
// hand-written sequences for byte lanes, busy starts, W1C and mid-op reset.
module tb_wb_serial_divmod;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat, la;
    logic        irq, hw_blink, sw_blink;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_serial_divmod #(.WBW(32), .LAW(32), .XLEN(32), .BASE_ADDR(BASE), .BLINK_W(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .la_data_o(la), .irq_o(irq), .hw_blinky_o(hw_blink), .sw_blinky_o(sw_blink)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd_o);
        bit got = 0;
        adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        rd_o = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL wb_ack_timeout actual=0 required=1 addr=0x%08h", a);
        end
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(BASE | 32'(off), 1'b1, d, s, dummy);
    endtask

    task automatic rd_reg(input logic [7:0] off, output logic [31:0] d);
        wb_xfer(BASE | 32'(off), 1'b0, 32'h0, 4'hF, d);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (la[3] && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL busy_timeout actual=%0d required<200", n);
        end
    endtask

    logic [31:0] v;
    int n;
    bit seen;

    initial begin
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0};
        vecs[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1};
        vecs[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
        vecs[8] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          1'b0, 1'b0};
        vecs[9] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0};

        reset = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_dat", rdat, 32'd0);
        chk("reset_la", la, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_blinkies", {30'd0, hw_blink, sw_blink}, 32'd0);
        reset = 1'b0;
        rd_reg(8'h10, v); chk("reset_quot", v, 32'd0);
        rd_reg(8'h0C, v); chk("reset_status", v, 32'd0);

        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (hw_blink) seen = 1;
        end
        chk("hw_blinky_toggles", 32'(seen), 32'd1);

        wr_reg(8'h08, 32'h0000_000C, 4'hF);
        rd_reg(8'h08, v); chk("ctrl_readback", v, 32'h0000_000C);
        chk("sw_blinky", 32'(sw_blink), 32'd1);

        wr_reg(8'h00, 32'h0, 4'hF);
        wr_reg(8'h00, 32'hAABB_CCDD, 4'b0010);
        rd_reg(8'h00, v); chk("byte_lane_dividend", v, 32'h0000_CC00);
        rd_reg(8'h20, v); chk("unmapped_read", v, 32'd0);
        wb_xfer(32'h4000_0004, 1'b0, 32'h0, 4'hF, v); chk("foreign_base_read", v, 32'd0);

        for (int i = 0; i < 10; i++) begin
            wr_reg(8'h00, vecs[i].a, 4'hF);
            wr_reg(8'h04, vecs[i].b, 4'hF);
            wr_reg(8'h08, 32'h5 | (32'(vecs[i].sgn) << 1), 4'hF);
            wait_idle(n);
            chk($sformatf("v%0d_busy_clocks", i), 32'(n), (vecs[i].dz || vecs[i].ov) ? 32'd2 : 32'd34);
            rd_reg(8'h10, v); chk($sformatf("v%0d_quot", i), v, vecs[i].q);
            rd_reg(8'h14, v); chk($sformatf("v%0d_rem", i), v, vecs[i].r);
            rd_reg(8'h0C, v);
            chk($sformatf("v%0d_status", i), v, 32'({vecs[i].ov, vecs[i].dz, 1'b1, 1'b0}));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'd1);
        end

        wr_reg(8'h0C, 32'h2, 4'h1);
        rd_reg(8'h0C, v); chk("w1c_done_status", v, 32'd0);
        chk("w1c_done_irq", 32'(irq), 32'd0);

        // Start while busy must be ignored; new operands wait for the next start.
        wr_reg(8'h00, 32'd100, 4'hF);
        wr_reg(8'h04, 32'd7, 4'hF);
        wr_reg(8'h08, 32'h5, 4'hF);
        rd_reg(8'h10, v); chk("read_while_busy_old_quot", v, vecs[9].q);
        wr_reg(8'h00, 32'd50, 4'hF);
        wr_reg(8'h04, 32'd5, 4'hF);
        wr_reg(8'h08, 32'h5, 4'hF);
        chk("still_iter_after_restart", {29'd0, la[2:0]}, 32'd2);
        wait_idle(n);
        rd_reg(8'h10, v); chk("ignored_start_quot", v, 32'd14);
        rd_reg(8'h14, v); chk("ignored_start_rem", v, 32'd2);
        wr_reg(8'h08, 32'h5, 4'hF);
        wait_idle(n);
        rd_reg(8'h10, v); chk("next_start_quot", v, 32'd10);
        rd_reg(8'h14, v); chk("next_start_rem", v, 32'd0);

        wr_reg(8'h00, 32'd100, 4'hF);
        wr_reg(8'h04, 32'd7, 4'hF);
        wr_reg(8'h08, 32'h5, 4'hF);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (la[2:0] == 3'd2 && la[15:8] == 8'd10) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reached_iter_10", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midop_reset_la", la, 32'd0);
        chk("midop_reset_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        rd_reg(8'h10, v); chk("midop_reset_quot", v, 32'd0);
        rd_reg(8'h14, v); chk("midop_reset_rem", v, 32'd0);
        rd_reg(8'h0C, v); chk("midop_reset_status", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
